extrinsic_reorder: RTL

Downstream neighbour of the SISO decoder core. The beta/LLR stage emits extrinsic LLRs in reverse trellis order (bit K-1 first). This block buffers one block of K extrinsic values and replays them in natural order (bit 0 first), scaled by 0.75, over a valid/ready stream. Its output feeds the interleaver and the a-priori input of the next half-iteration.

---
 rtl/extrinsic_reorder_pkg.sv | 25 ++
 rtl/ext_buf_ram.sv | 35 +++
 rtl/extrinsic_reorder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/extrinsic_reorder_pkg.sv
// Shared decoder-wide definitions: LLR sizing, block limits, reorder FSM states, 0.75 scaling.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package extrinsic_reorder_pkg;

  localparam int DATA_W  = 16;    // LLR width, two's complement
  localparam int MAX_BLK = 6144;  // largest block length K
  localparam int ADDR_W  = 13;    // buffer address width, 2^ADDR_W >= MAX_BLK
  localparam int LEN_W   = 16;    // width of the blklen field

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef logic signed [DATA_W-1:0] llr_t;

  // 0.75 * e as (e >>> 1) + (e >>> 2): floor rounding on each term.
  // The sum magnitude never exceeds the input range, so no saturation.
  function automatic llr_t scale_3q(input llr_t e);
    return (e >>> 1) + (e >>> 2);
  endfunction

endpackage

// File: rtl/ext_buf_ram.sv
// Simple dual-port block buffer for one decoder block of extrinsic LLRs.
// Latency: 1 cycle from rd_en to rd_dat; write visible to reads on the next cycle.
// Backpressure: none; rd_dat holds its value while rd_en is low.
//
// Ports:
//   clk              - single clock
//   wr_en/wr_addr/wr_dat - write port
//   rd_en/rd_addr    - read request, registered output on rd_dat
module ext_buf_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 6144,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on storage or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/extrinsic_reorder.sv
// Buffers one block of K extrinsic LLRs (arriving bit K-1 first), replays them bit 0 first scaled by 0.75.
// Latency: first ext_valid two cycles after the last write; then one output per cycle under ext_ready.
// Backpressure: none on the input side; output uses a 2-entry skid buffer, RAM reads stall when it is full.
//
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   blklen/valid_blklen/ready   - block length handshake, accepted only in IDLE
//   blklen_err                  - one-cycle pulse for an illegal blklen
//   extrinsic/valid_extrinsic   - input LLR stream, reverse trellis order
//   ext_out/ext_valid/ext_ready - scaled output stream, natural order
//   ext_last                    - marks the transfer of bit K-1
module extrinsic_reorder
  import extrinsic_reorder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  blklen,
  input  logic              valid_blklen,
  input  logic [DATA_W-1:0] extrinsic,
  input  logic              valid_extrinsic,
  output logic              ready,
  output logic              blklen_err,
  output logic [DATA_W-1:0] ext_out,
  output logic              ext_valid,
  input  logic              ext_ready,
  output logic              ext_last
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] out_cnt_q;

  logic              blklen_ok;
  logic              blklen_bad;
  logic              blk_start;
  logic              wr_en;
  logic              rd_en;
  logic              ram_vld_q;   // rd_dat carries a fresh RAM word this cycle
  logic [DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0] wr_dat;

  logic [DATA_W-1:0] skid0_q;     // head entry
  logic [DATA_W-1:0] skid1_q;
  logic [1:0]        skid_cnt_q;
  logic [2:0]        occ;
  logic              fire;
  logic              last_fire;
  logic              push;
  logic              pop;

  assign blklen_ok = (blklen != '0) && (blklen <= LEN_W'(MAX_BLK));
  assign wr_dat    = scale_3q(extrinsic);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    blk_start  = 1'b0;
    blklen_bad = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (valid_blklen) begin
          if (blklen_ok) begin
            blk_start = 1'b1;
            state_d   = ST_FILL;
          end else begin
            blklen_bad = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (valid_extrinsic) begin
          wr_en = 1'b1;
          if (wr_addr_q == '0) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (last_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output side: RAM word is presented directly when the skid buffer is empty,
  // so the first beat appears one cycle after the read and no bubble is added.
  // ---------------------------------------------------------------------------
  assign ext_valid = (skid_cnt_q != 2'd0) || ram_vld_q;
  assign fire      = ext_valid && ext_ready;
  assign ext_last  = ext_valid && (state_q == ST_DRAIN) &&
                     (out_cnt_q == (k_q - ADDR_W'(1)));
  assign last_fire = fire && ext_last;
  assign ext_out   = !ext_valid ? '0 :
                     (skid_cnt_q != 2'd0) ? skid0_q : rd_dat;

  // Words still held after this cycle's transfer. A new read is only issued
  // when that leaves room for its result, so the two entries never overflow.
  assign occ   = 3'(skid_cnt_q) + 3'(ram_vld_q) - 3'(fire);
  assign rd_en = (state_q == ST_DRAIN) && (rd_addr_q < k_q) && (occ <= 3'd1);

  // RAM word not consumed directly must be parked in the skid buffer.
  assign push = ram_vld_q && !(fire && (skid_cnt_q == 2'd0));
  assign pop  = fire && (skid_cnt_q != 2'd0);

  // ---------------------------------------------------------------------------
  // State, counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      out_cnt_q  <= '0;
      ram_vld_q  <= 1'b0;
      blklen_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      blklen_err <= blklen_bad;
      ram_vld_q  <= rd_en;
      if (blk_start) begin
        k_q       <= blklen[ADDR_W-1:0];
        wr_addr_q <= ADDR_W'(blklen - LEN_W'(1));
        rd_addr_q <= '0;
        out_cnt_q <= '0;
      end
      if (wr_en) begin
        wr_addr_q <= wr_addr_q - ADDR_W'(1);
      end
      if (rd_en) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end
      if (fire) begin
        out_cnt_q <= out_cnt_q + ADDR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (skid_cnt_q == 2'd0) begin
            skid0_q <= rd_dat;
          end else begin
            skid1_q <= rd_dat;
          end
          skid_cnt_q <= skid_cnt_q + 2'd1;
        end
        2'b01: begin
          skid0_q    <= skid1_q;
          skid_cnt_q <= skid_cnt_q - 2'd1;
        end
        2'b11: begin
          if (skid_cnt_q == 2'd1) begin
            skid0_q <= rd_dat;
          end else begin
            skid0_q <= skid1_q;
            skid1_q <= rd_dat;
          end
        end
        default: begin
        end
      endcase
    end
  end

  ext_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_BLK),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr_q),
    .wr_dat  (wr_dat),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .rd_dat  (rd_dat)
  );

endmodule
